// File: rtl/regfile_mp.sv
`default_nettype none
// regfile_mp: multi-port GPR array with a per-register busy scoreboard; r0 reads as zero.
// Optional write-to-read forwarding with RF_BYPASS_EN. Rev 1.0
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2,
  parameter int NR_WRITE   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NR_WRITE-1:0]            wen,
  input  logic [NR_WRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NR_WRITE*DATA_WIDTH-1:0] wdata,
  input  logic [NR_READ*ADDR_WIDTH-1:0]  raddr,
  output logic [NR_READ*DATA_WIDTH-1:0]  rdata,
  output logic [NR_READ-1:0]             rbusy,
  input  logic                           issue_en,
  input  logic [ADDR_WIDTH-1:0]          issue_addr,
  output logic                           conflict_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DATA_WIDTH-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic                  conflict_q, conflict_d;
  logic [NR_WRITE-1:0]   wr_eff;

  for (genvar k = 0; k < NR_WRITE; k++) begin : g_wr
    assign wr_eff[k] = wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0);
  end

  // Ascending port order lets the higher-index port win; issue is applied last so set beats clear.
  always_comb begin
    rf_d       = rf_q;
    busy_d     = busy_q;
    conflict_d = conflict_q;
    for (int k = 0; k < NR_WRITE; k++) begin
      if (wr_eff[k]) begin
        rf_d[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]]   = wdata[k*DATA_WIDTH +: DATA_WIDTH];
        busy_d[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (issue_en && (issue_addr != '0)) begin
      busy_d[issue_addr] = 1'b1;
    end
    for (int k = 1; k < NR_WRITE; k++) begin
      for (int j = 0; j < k; j++) begin
        if (wr_eff[k] && wr_eff[j] &&
            (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == waddr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q       <= '{default: '0};
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      rf_q       <= rf_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign conflict_err = conflict_q;

  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = rf_q[ra];
      rb = busy_q[ra];
`ifdef RF_BYPASS_EN
      // Forwarding is gated by reset so reads stay zero while reset is held.
      if (rst_n) begin
        for (int k = 0; k < NR_WRITE; k++) begin
          if (wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
            rd = wdata[k*DATA_WIDTH +: DATA_WIDTH];
            rb = issue_en && (issue_addr == ra);
          end
        end
      end
`endif
      if (ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[i]                          = rb;
  end

endmodule
`default_nettype wire
